// File: rtl/systolic_matmul_engine.sv
// rtl/systolic_matmul_engine.sv - self-sequencing ROWSxCOLS fixed-point systolic matmul engine
// Optional SYSTOLIC_SATURATE_EN: clamp products and saturate accumulation instead of wrapping.
module systolic_matmul_engine #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int NBITS = 16,
  parameter int DBITS = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_val,
  output logic                       cmd_rdy,
  input  logic [$clog2(DEPTH+1)-1:0] cmd_k,
  input  logic                       x_val,
  output logic                       x_rdy,
  input  logic [ROWS*NBITS-1:0]      x_msg,
  input  logic                       w_val,
  output logic                       w_rdy,
  input  logic [COLS*NBITS-1:0]      w_msg,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [NBITS-1:0]           out_msg,
  output logic                       out_last,
  output logic                       busy
);
  localparam int KW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(DEPTH + ROWS + COLS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
`ifdef SYSTOLIC_SATURATE_EN
  localparam logic signed [2*NBITS-1:0] PMAX = {{(NBITS+1){1'b0}}, {(NBITS-1){1'b1}}};
  localparam logic signed [2*NBITS-1:0] PMIN = {{(NBITS+1){1'b1}}, {(NBITS-1){1'b0}}};
  localparam logic signed [NBITS-1:0]   SMAX = {1'b0, {(NBITS-1){1'b1}}};
  localparam logic signed [NBITS-1:0]   SMIN = {1'b1, {(NBITS-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;
  state_t state, state_nxt;

  logic [KW-1:0] k_reg, x_cnt, w_cnt, k_new, x_cnt_nxt, w_cnt_nxt;
  logic [TW-1:0] t_cnt, t_last;
  logic [RW-1:0] r_idx;
  logic [CW-1:0] c_idx;
  logic          cmd_fire, x_fire, w_fire, out_fire;

  logic signed [NBITS-1:0] x_mem  [ROWS][DEPTH];
  logic signed [NBITS-1:0] w_mem  [COLS][DEPTH];
  logic signed [NBITS-1:0] x_pipe [ROWS][COLS];
  logic signed [NBITS-1:0] w_pipe [ROWS][COLS];
  logic signed [NBITS-1:0] pe_x   [ROWS][COLS];
  logic signed [NBITS-1:0] pe_w   [ROWS][COLS];
  logic signed [NBITS-1:0] acc    [ROWS][COLS];
  logic signed [NBITS-1:0] x_inj  [ROWS];
  logic signed [NBITS-1:0] w_inj  [COLS];

  // Shift the full-width product down to the fixed-point grid, then accumulate.
  function automatic logic signed [NBITS-1:0] mac(input logic signed [NBITS-1:0] a,
                                                   input logic signed [NBITS-1:0] x,
                                                   input logic signed [NBITS-1:0] w);
    logic signed [2*NBITS-1:0] p;
`ifdef SYSTOLIC_SATURATE_EN
    logic signed [2*NBITS-1:0] sh;
    logic signed [NBITS-1:0]   pc;
    logic        [NBITS:0]     s;
`endif
    p = x * w;
`ifdef SYSTOLIC_SATURATE_EN
    sh = p >>> DBITS;
    if (sh > PMAX)      pc = SMAX;
    else if (sh < PMIN) pc = SMIN;
    else                pc = sh[NBITS-1:0];
    s = {a[NBITS-1], a} + {pc[NBITS-1], pc};
    if (s[NBITS] != s[NBITS-1]) mac = s[NBITS] ? SMIN : SMAX;
    else                        mac = s[NBITS-1:0];
`else
    mac = a + NBITS'(p >>> DBITS);
`endif
  endfunction

  assign k_new     = (cmd_k > KW'(DEPTH)) ? KW'(DEPTH) : cmd_k;
  assign cmd_rdy   = !rst && state == IDLE;
  assign x_rdy     = !rst && state == LOAD && x_cnt < k_reg;
  assign w_rdy     = !rst && state == LOAD && w_cnt < k_reg;
  assign out_val   = !rst && state == DRAIN;
  assign busy      = !rst && state != IDLE;
  assign out_last  = out_val && r_idx == RW'(ROWS-1) && c_idx == CW'(COLS-1);
  assign out_msg   = out_val ? acc[r_idx][c_idx] : '0;
  assign cmd_fire  = cmd_val && cmd_rdy;
  assign x_fire    = x_val && x_rdy;
  assign w_fire    = w_val && w_rdy;
  assign out_fire  = out_val && out_rdy;
  assign x_cnt_nxt = x_cnt + KW'(x_fire);
  assign w_cnt_nxt = w_cnt + KW'(w_fire);
  assign t_last    = TW'(k_reg) + TW'(ROWS + COLS - 3);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire) state_nxt = (k_new == '0) ? DRAIN : LOAD;
      LOAD:    if (x_cnt_nxt == k_reg && w_cnt_nxt == k_reg) state_nxt = COMPUTE;
      COMPUTE: if (t_cnt == t_last) state_nxt = DRAIN;
      DRAIN:   if (out_fire && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k_reg <= '0;
      x_cnt <= '0;
      w_cnt <= '0;
      t_cnt <= '0;
      r_idx <= '0;
      c_idx <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_fire) begin
        k_reg <= k_new;
        x_cnt <= '0;
        w_cnt <= '0;
        t_cnt <= '0;
        r_idx <= '0;
        c_idx <= '0;
      end
      if (x_fire) x_cnt <= x_cnt_nxt;
      if (w_fire) w_cnt <= w_cnt_nxt;
      if (state == COMPUTE) t_cnt <= t_cnt + 1'b1;
      if (out_fire) begin
        if (c_idx == CW'(COLS-1)) begin
          c_idx <= '0;
          r_idx <= r_idx + 1'b1;
        end else begin
          c_idx <= c_idx + 1'b1;
        end
      end
    end
  end

  // Lane buffers need no reset: only entries written by the current command are read.
  always_ff @(posedge clk) begin
    if (x_fire) for (int i = 0; i < ROWS; i++) x_mem[i][x_cnt[AW-1:0]] <= x_msg[i*NBITS +: NBITS];
    if (w_fire) for (int j = 0; j < COLS; j++) w_mem[j][w_cnt[AW-1:0]] <= w_msg[j*NBITS +: NBITS];
  end

  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      x_inj[i] = '0;
      if (int'(t_cnt) >= i && int'(t_cnt) < i + int'(k_reg)) x_inj[i] = x_mem[i][AW'(int'(t_cnt) - i)];
    end
    for (int j = 0; j < COLS; j++) begin
      w_inj[j] = '0;
      if (int'(t_cnt) >= j && int'(t_cnt) < j + int'(k_reg)) w_inj[j] = w_mem[j][AW'(int'(t_cnt) - j)];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      if (j == 0) begin : g_xl
        assign pe_x[i][j] = x_inj[i];
      end else begin : g_xp
        assign pe_x[i][j] = x_pipe[i][j-1];
      end
      if (i == 0) begin : g_wt
        assign pe_w[i][j] = w_inj[j];
      end else begin : g_wp
        assign pe_w[i][j] = w_pipe[i-1][j];
      end
    end
  end

  // Pipelines are cleared on accept so the previous tile's tail never leaks in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          x_pipe[i][j] <= '0;
          w_pipe[i][j] <= '0;
          acc[i][j]    <= '0;
        end
    end else if (cmd_fire) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          x_pipe[i][j] <= '0;
          w_pipe[i][j] <= '0;
          acc[i][j]    <= '0;
        end
    end else if (state == COMPUTE) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          x_pipe[i][j] <= pe_x[i][j];
          w_pipe[i][j] <= pe_w[i][j];
          acc[i][j]    <= mac(acc[i][j], pe_x[i][j], pe_w[i][j]);
        end
    end
  end
endmodule

// File: doc/systolic_matmul_engine.md
# systolic_matmul_engine

Self-sequencing, rectangular, fixed-point systolic matrix-multiply engine with streaming valid/ready interfaces. It accepts a command with inner dimension K. It buffers K operand vectors per side in per-lane FIFOs and generates the diagonal input skew internally. It then drains the ROWS×COLS result tile in row-major order. It replaces externally sequenced square datapaths in the accelerator, and the surrounding controller only issues commands and moves streams.

## Interface
- ROWS, 4, PE rows; number of x lanes
- COLS, 4, PE columns; number of w lanes
- NBITS, 16, signed fixed-point word width
- DBITS, 8, fractional bits
- DEPTH, 8, per-lane FIFO depth; maximum K
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cmd_val / cmd_rdy  in/out  1  command handshake
- cmd_k  in  $clog2(DEPTH+1)  inner dimension K
- x_val / x_rdy  in/out  1  x-vector handshake
- x_msg  in  ROWS*NBITS  x vector; lane i at [i*NBITS +: NBITS]
- w_val / w_rdy  in/out  1  w-vector handshake
- w_msg  in  COLS*NBITS  w vector; lane j at [j*NBITS +: NBITS]
- out_val / out_rdy  out/in  1  result handshake
- out_msg  out  NBITS  result element
- out_last  out  1  marks element (ROWS-1, COLS-1)
- busy  out  1  state ≠ IDLE

## Operation
- Handshake: a transfer occurs when val && rdy are both high on a rising clk edge.
- FSM states are IDLE, LOAD, COMPUTE and DRAIN.
- IDLE:
  - cmd_rdy=1.
  - On accept, latch K = min(cmd_k, DEPTH) and clear all accumulators to 0.
  - If K=0, go to DRAIN; otherwise go to LOAD.
- LOAD:
  - x_rdy stays high until K x vectors have been accepted; w_rdy stays high until K w vectors have been accepted. The two sides are independent and may arrive in any order or interleaving.
  - Each vector is written lane-wise into the lane FIFOs.
  - When both counts equal K, go to COMPUTE.
  - Outside LOAD, x_rdy=w_rdy=0.
- COMPUTE:
  - Skew counter t runs from 0 to K+ROWS+COLS-3.
  - x lane i injects FIFO element t-i when i ≤ t < i+K, and 0 otherwise. w lane j behaves the same way with j.
  - PE(i,j) accumulates x_in*w_in every cycle. It forwards x right and w down through 1-cycle registers, so it sees element k at t=k+i+j.
  - After the final cycle, go to DRAIN.
- DRAIN:
  - out_val=1 and out_msg=s[r][c], with the index advancing row-major on each transfer.
  - out_msg and out_last are held stable while out_rdy=0.
  - After the transfer with out_last, go to IDLE. The FIFOs are empty at this point.
- Arithmetic:
  - Form the full 2*NBITS signed product.
  - Arithmetic-shift it right by DBITS and truncate to NBITS.
  - The accumulator adds modulo 2^NBITS (two's-complement wrap).
- Reset (including mid-operation):
  - State returns to IDLE, FIFOs are flushed, and accumulators, PE pipeline registers and counters are cleared.
  - While rst is high, cmd_rdy, x_rdy, w_rdy, out_val, out_last and busy are forced to 0, and out_msg is 0.
- Inputs that arrive while not ready (for example x_val in IDLE) are ignored.

## Timing
- Command accept: 1 cycle; busy rises the cycle after the accept.
- LOAD at full throughput takes K cycles.
- COMPUTE takes exactly K+ROWS+COLS-2 cycles.
- out_val rises the first cycle after COMPUTE ends.
- DRAIN takes ROWS*COLS cycles when out_rdy is held high.
- cmd_rdy re-asserts the cycle after the out_last transfer. There is no overlap between consecutive commands.

## Configuration
- SYSTOLIC_SATURATE_EN defined:
  - The shifted product is clamped to [-2^(NBITS-1), 2^(NBITS-1)-1].
  - Accumulator addition saturates to the same range.
- Undefined: truncate and wrap exactly as described under Arithmetic.

## Test plan
All scenarios use ROWS=COLS=2, NBITS=16, DBITS=8, DEPTH=8.
- K=1, x=[0x0100,0x0200], w=[0x0300,0x0100] -> out 0x0300, 0x0100, 0x0600, 0x0200; out_last only on the 4th.
- K=8, all x and w = 0x0100, w streamed entirely before x -> four outputs of 0x0800; exactly 10 COMPUTE cycles between the last load and out_val.
- Same as scenario 1 with out_rdy toggled every other cycle -> identical sequence; out_msg and out_last stable while stalled; no duplicates or drops.
- K=1, x=[0x7F00,0], w=[0x0200,0] -> s[0][0]=0xFE00 without the macro, 0x7FFF with SYSTOLIC_SATURATE_EN.
- rst pulsed mid-COMPUTE during a K=8 run -> all outputs 0 while asserted; the following scenario-1 command reproduces scenario-1 results (no stale data).
- cmd_k=0 -> four zero outputs with no LOAD; cmd_k=12 -> clamped to K=8, and x_rdy drops after 8 accepted vectors.
